// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the control-bundle type used by the decode stage.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned RF_AW   = 5;
  localparam int unsigned ALU_W   = 4;
  localparam int unsigned OP_W    = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;

  localparam logic [OP_W-1:0] F_ADD = 6'h20;
  localparam logic [OP_W-1:0] F_SUB = 6'h22;
  localparam logic [OP_W-1:0] F_AND = 6'h24;
  localparam logic [OP_W-1:0] F_OR  = 6'h25;
  localparam logic [OP_W-1:0] F_SLT = 6'h2A;

  localparam logic [ALU_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_W-1:0] ALU_AND = 4'd2;
  localparam logic [ALU_W-1:0] ALU_OR  = 4'd3;
  localparam logic [ALU_W-1:0] ALU_SLT = 4'd4;

  typedef struct packed {
    logic [ALU_W-1:0] alu_op;
    logic             alu_src;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             branch;
    logic             jump;
    logic             illegal;
  } ctrl_t;

endpackage

// File: rtl/mips_control_decode.sv
// Combinational instruction decoder: fields, control bundle, destination and rt usage.
module mips_control_decode
  import mips_pkg::*;
(
  input  logic [INSTR_W-1:0] i_instr,
  output logic [RF_AW-1:0]   o_rs,
  output logic [RF_AW-1:0]   o_rt,
  output logic [RF_AW-1:0]   o_dest,
  output logic [INSTR_W-1:0] o_imm,
  output logic               o_uses_rt,
  output ctrl_t              o_ctrl
);

  logic [OP_W-1:0]  w_op;
  logic [OP_W-1:0]  w_funct;
  logic [RF_AW-1:0] w_rd;
  logic [RF_AW-1:0] w_shamt;

  assign w_op    = i_instr[31:26];
  assign o_rs    = i_instr[25:21];
  assign o_rt    = i_instr[20:16];
  assign w_rd    = i_instr[15:11];
  assign w_shamt = i_instr[10:6];
  assign w_funct = i_instr[5:0];
  assign o_imm   = {{16{i_instr[15]}}, i_instr[15:0]};

  always_comb begin
    o_ctrl    = '0;
    o_dest    = '0;
    o_uses_rt = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        o_uses_rt        = 1'b1;
        o_dest           = w_rd;
        o_ctrl.reg_write = 1'b1;
        case (w_funct)
          F_ADD:   o_ctrl.alu_op = ALU_ADD;
          F_SUB:   o_ctrl.alu_op = ALU_SUB;
          F_AND:   o_ctrl.alu_op = ALU_AND;
          F_OR:    o_ctrl.alu_op = ALU_OR;
          F_SLT:   o_ctrl.alu_op = ALU_SLT;
          default: begin
            o_ctrl         = '0;
            o_dest         = '0;
            o_ctrl.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin
        o_dest           = o_rt;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      OP_LW: begin
        o_dest            = o_rt;
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_read   = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        o_uses_rt        = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.mem_write = 1'b1;
      end
      OP_BEQ: begin
        o_uses_rt     = 1'b1;
        o_ctrl.alu_op = ALU_SUB;
        o_ctrl.branch = 1'b1;
      end
      OP_J:    o_ctrl.jump    = 1'b1;
      default: o_ctrl.illegal = 1'b1;
    endcase
    // Writes to $0 are architectural no-ops
    if (o_dest == '0) o_ctrl.reg_write = 1'b0;
  end

  logic w_unused;
  assign w_unused = ^w_shamt;

endmodule

// File: rtl/mips_decode_stage.sv
// ID stage: register-file addressing, writeback bypass, load-use stall and ID/EX register.
module mips_decode_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [DATA_W-1:0] in_pc,
  output logic [REG_AW-1:0] reg_read_addr_1,
  output logic [REG_AW-1:0] reg_read_addr_2,
  input  logic [DATA_W-1:0] reg_read_data_1,
  input  logic [DATA_W-1:0] reg_read_data_2,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_rs_val,
  output logic [DATA_W-1:0] ex_rt_val,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_dest,
  output logic [ALU_W-1:0]  ex_alu_op,
  output logic              ex_alu_src,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_branch,
  output logic              ex_jump,
  output logic              ex_illegal
);

  logic [RF_AW-1:0]   w_rs_f;
  logic [RF_AW-1:0]   w_rt_f;
  logic [RF_AW-1:0]   w_dest_f;
  logic [INSTR_W-1:0] w_imm_f;
  logic               w_uses_rt;
  ctrl_t              w_ctrl;

  mips_control_decode u_dec (
    .i_instr   (INSTR_W'(in_instr)),
    .o_rs      (w_rs_f),
    .o_rt      (w_rt_f),
    .o_dest    (w_dest_f),
    .o_imm     (w_imm_f),
    .o_uses_rt (w_uses_rt),
    .o_ctrl    (w_ctrl)
  );

  logic [REG_AW-1:0] w_rs;
  logic [REG_AW-1:0] w_rt;
  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_rt_val;
  logic              w_load;
  logic              w_hazard;

  assign w_rs            = REG_AW'(w_rs_f);
  assign w_rt            = REG_AW'(w_rt_f);
  assign reg_read_addr_1 = w_rs;
  assign reg_read_addr_2 = w_rt;

  // $0 reads as zero; otherwise same-cycle writeback wins over the stale file read
  assign w_rs_val = (w_rs == '0) ? '0 :
                    (wb_en && (wb_dest == w_rs)) ? wb_data : reg_read_data_1;
  assign w_rt_val = (w_rt == '0) ? '0 :
                    (wb_en && (wb_dest == w_rt)) ? wb_data : reg_read_data_2;

  assign w_load   = !out_valid || out_ready;
  assign w_hazard = out_valid && ex_mem_read && (ex_dest != '0) &&
                    ((ex_dest == w_rs) || ((ex_dest == w_rt) && w_uses_rt));
  assign in_ready = flush || (w_load && !w_hazard);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid     <= 1'b0;
      ex_pc         <= '0;
      ex_rs_val     <= '0;
      ex_rt_val     <= '0;
      ex_imm        <= '0;
      ex_dest       <= '0;
      ex_alu_op     <= '0;
      ex_alu_src    <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_branch     <= 1'b0;
      ex_jump       <= 1'b0;
      ex_illegal    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (w_load) begin
      if (in_valid && !w_hazard) begin
        out_valid     <= 1'b1;
        ex_pc         <= in_pc;
        ex_rs_val     <= w_rs_val;
        ex_rt_val     <= w_rt_val;
        ex_imm        <= DATA_W'(w_imm_f);
        ex_dest       <= REG_AW'(w_dest_f);
        ex_alu_op     <= w_ctrl.alu_op;
        ex_alu_src    <= w_ctrl.alu_src;
        ex_reg_write  <= w_ctrl.reg_write;
        ex_mem_read   <= w_ctrl.mem_read;
        ex_mem_write  <= w_ctrl.mem_write;
        ex_mem_to_reg <= w_ctrl.mem_to_reg;
        ex_branch     <= w_ctrl.branch;
        ex_jump       <= w_ctrl.jump;
        ex_illegal    <= w_ctrl.illegal;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
